// File: rtl/issue_dispatch_pkg.sv
// -----------------------------------------------------------------------------
// issue_dispatch_pkg
//
// Shared definitions for the in-order dispatch scheduler that sits between
// rename and the reservation-station bank.
//
// Contents:
//   rs_class_e        - functional-unit class encodings; rename uses these as
//                       the RS index it presents on rn_rs_sel
//   lg2_to_count()    - turns a log2 configuration parameter into a count
// -----------------------------------------------------------------------------
package issue_dispatch_pkg;

    // Reservation-station class encodings (index into the RS bank).
    typedef enum logic [1:0] {
        RS_CLASS_ALU = 2'd0,
        RS_CLASS_LSU = 2'd1,
        RS_CLASS_BRU = 2'd2,
        RS_CLASS_EPU = 2'd3
    } rs_class_e;

    // Number of items described by a log2 configuration parameter.
    function automatic int unsigned lg2_to_count(input int unsigned lg);
        return 32'd1 << lg;
    endfunction

endpackage

// File: rtl/issue_dispatch_sel.sv
// -----------------------------------------------------------------------------
// issue_dispatch_sel
//
// Combinational in-order claim logic of the dispatcher. Scans the held group
// from the oldest slot (slot 0) to the youngest and decides which slots are
// pushed into their reservation station this cycle.
//
// A slot goes only when:
//   - it is still pending,
//   - its target RS is not full,
//   - every older pending slot also goes (strict in-order dispatch),
//   - no older slot going this cycle already claimed the same RS.
// The first pending slot that cannot go blocks all younger slots.
//
// Ports:
//   pend     in  IW        slots of the held group not yet dispatched
//   sel      in  IW*SEL_W  per-slot target RS index
//   rs_full  in  NRS       per-RS full flag
//   go       out IW        per-slot dispatch grant for this cycle
// -----------------------------------------------------------------------------
module issue_dispatch_sel #(
    parameter int IW    = 2,
    parameter int NRS   = 4,
    parameter int SEL_W = 2
) (
    input  logic [IW-1:0]       pend,
    input  logic [IW*SEL_W-1:0] sel,
    input  logic [NRS-1:0]      rs_full,
    output logic [IW-1:0]       go
);

    // Oldest-first scan: claim RS ports and stop at the first stuck slot.
    always_comb begin
        logic [NRS-1:0]   claimed_s;
        logic             blocked_s;
        logic [SEL_W-1:0] sel_i_s;

        go        = '0;
        claimed_s = '0;
        blocked_s = 1'b0;
        sel_i_s   = '0;
        for (int i = 0; i < IW; i++) begin
            sel_i_s = sel[i*SEL_W +: SEL_W];
            if (pend[i] && !blocked_s && !rs_full[sel_i_s] && !claimed_s[sel_i_s]) begin
                go[i]              = 1'b1;
                claimed_s[sel_i_s] = 1'b1;
            end else if (pend[i]) begin
                // Full RS or same-RS conflict: younger slots must wait.
                blocked_s = 1'b1;
            end else begin
                // Empty slot neither grants nor blocks.
                blocked_s = blocked_s;
            end
        end
    end

endmodule

// File: rtl/issue_dispatch.sv
// -----------------------------------------------------------------------------
// issue_dispatch
//
// In-order dispatch scheduler between rename and the bank of reservation
// stations. Latches one renamed issue group of up to IW slots and steers each
// valid slot to the RS chosen by its functional-unit class. Each RS takes at
// most one push per cycle, so slot-to-RS conflicts and RS-full stalls are
// serialized over several cycles; rename is backpressured until every slot
// of the held group has been pushed.
//
// Parameters:
//   CONFIG_P_ISSUE_WIDTH  log2 of issue group width (IW)
//   CONFIG_P_NUM_RS       log2 of reservation-station count (NRS)
//   PAYLOAD_W             width of one slot's opaque RS payload
//
// Ports:
//   clk            in   1              clock
//   rst            in   1              synchronous active-high reset
//   flush          in   1              pipeline flush, drops the held group
//   rn_valid       in   1              rename presents a group
//   rn_ready       out  1              group accepted this cycle
//   rn_slot_valid  in   IW             per-slot valid, slot 0 oldest
//   rn_rs_sel      in   IW*NUM_RS      per-slot target RS index
//   rn_payload     in   IW*PAYLOAD_W   per-slot payload
//   rs_full        in   NRS            per-RS full flag
//   rs_push        out  NRS            per-RS push strobe
//   rs_payload     out  NRS*PAYLOAD_W  per-RS payload (valid with rs_push)
// -----------------------------------------------------------------------------
module issue_dispatch
    import issue_dispatch_pkg::*;
#(
    parameter  int CONFIG_P_ISSUE_WIDTH = 1,
    parameter  int CONFIG_P_NUM_RS      = 2,
    parameter  int PAYLOAD_W            = 64,
    localparam int IW                   = int'(lg2_to_count(CONFIG_P_ISSUE_WIDTH)),
    localparam int NRS                  = int'(lg2_to_count(CONFIG_P_NUM_RS)),
    localparam int SEL_W                = CONFIG_P_NUM_RS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     rn_valid,
    output logic                     rn_ready,
    input  logic [IW-1:0]            rn_slot_valid,
    input  logic [IW*SEL_W-1:0]      rn_rs_sel,
    input  logic [IW*PAYLOAD_W-1:0]  rn_payload,
    input  logic [NRS-1:0]           rs_full,
    output logic [NRS-1:0]           rs_push,
    output logic [NRS*PAYLOAD_W-1:0] rs_payload
);

    // Held group: pending mask plus per-slot target and payload.
    logic [IW-1:0]           pend_r;
    logic [IW*SEL_W-1:0]     buf_sel_r;
    logic [IW*PAYLOAD_W-1:0] buf_payload_r;

    logic [IW-1:0] go_s;        // slots granted by the claim logic
    logic [IW-1:0] push_go_s;   // grants after flush suppression
    logic [IW-1:0] remain_s;    // slots still pending after this cycle
    logic          fire_s;      // new group accepted this cycle

    issue_dispatch_sel #(
        .IW    (IW),
        .NRS   (NRS),
        .SEL_W (SEL_W)
    ) u_sel (
        .pend    (pend_r),
        .sel     (buf_sel_r),
        .rs_full (rs_full),
        .go      (go_s)
    );

    // Handshake: ready once the held group drains this cycle; flush wins.
    always_comb begin
        remain_s  = pend_r & ~go_s;
        push_go_s = go_s & {IW{~flush}};
        rn_ready  = ~flush & ~(|remain_s);
        fire_s    = rn_valid & rn_ready;
    end

    // Route each granted slot to its RS; the claim logic guarantees at most
    // one granted slot per RS, so an AND-OR mux is sufficient.
    always_comb begin
        logic hit_s;

        rs_push    = '0;
        rs_payload = '0;
        hit_s      = 1'b0;
        for (int k = 0; k < NRS; k++) begin
            for (int i = 0; i < IW; i++) begin
                hit_s = push_go_s[i] & (buf_sel_r[i*SEL_W +: SEL_W] == SEL_W'(k));
                rs_push[k] = rs_push[k] | hit_s;
                rs_payload[k*PAYLOAD_W +: PAYLOAD_W] = rs_payload[k*PAYLOAD_W +: PAYLOAD_W]
                    | ({PAYLOAD_W{hit_s}} & buf_payload_r[i*PAYLOAD_W +: PAYLOAD_W]);
            end
        end
    end

    // Pending mask and group buffer update. On accept the old group has
    // already drained (rn_ready implies it), so the new valid mask simply
    // replaces pend.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r        <= '0;
            buf_sel_r     <= '0;
            buf_payload_r <= '0;
        end else if (flush) begin
            pend_r        <= '0;
        end else if (fire_s) begin
            pend_r        <= rn_slot_valid;
            buf_sel_r     <= rn_rs_sel;
            buf_payload_r <= rn_payload;
        end else begin
            pend_r        <= remain_s;
        end
    end

endmodule

// File: tb/tb_issue_dispatch.sv
// -----------------------------------------------------------------------------
// tb_issue_dispatch
//
// Self-checking bench for issue_dispatch with IW=2, NRS=4, PAYLOAD_W=8.
// A queue of pending slots (oldest first) serves as the reference: each cycle
// the leading slots whose RS is free and not yet used this cycle are popped.
// -----------------------------------------------------------------------------
module tb_issue_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        rn_valid;
    logic        rn_ready;
    logic [1:0]  rn_slot_valid;
    logic [3:0]  rn_rs_sel;
    logic [15:0] rn_payload;
    logic [3:0]  rs_full;
    logic [3:0]  rs_push;
    logic [31:0] rs_payload;

    issue_dispatch #(
        .CONFIG_P_ISSUE_WIDTH (1),
        .CONFIG_P_NUM_RS      (2),
        .PAYLOAD_W            (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .rn_valid      (rn_valid),
        .rn_ready      (rn_ready),
        .rn_slot_valid (rn_slot_valid),
        .rn_rs_sel     (rn_rs_sel),
        .rn_payload    (rn_payload),
        .rs_full       (rs_full),
        .rs_push       (rs_push),
        .rs_payload    (rs_payload)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [1:0] rs;
        logic [7:0] pl;
    } slot_t;

    slot_t       mq[$];
    logic [3:0]  obs_push;
    logic        obs_ready;
    logic [31:0] obs_payload;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at negedge, compare before posedge, advance model.
    task automatic step(input logic r, input logic f, input logic v,
                        input logic [1:0] sv, input logic [3:0] sel,
                        input logic [15:0] pl, input logic [3:0] full);
        logic [3:0] e_push;
        logic [7:0] e_pl[4];
        logic       e_ready;
        int         n_go;

        @(negedge clk);
        rst           = r;
        flush         = f;
        rn_valid      = v;
        rn_slot_valid = sv;
        rn_rs_sel     = sel;
        rn_payload    = pl;
        rs_full       = full;
        #1;
        e_push = 4'd0;
        n_go   = 0;
        for (int k = 0; k < 4; k++) e_pl[k] = 8'd0;
        for (int i = 0; i < mq.size(); i++) begin
            if (!full[mq[i].rs] && !e_push[mq[i].rs]) begin
                e_push[mq[i].rs] = 1'b1;
                e_pl[mq[i].rs]   = mq[i].pl;
                n_go++;
            end else begin
                break;
            end
        end
        e_ready = (n_go == mq.size());
        if (f) begin
            e_push  = 4'd0;
            e_ready = 1'b0;
        end
        obs_push    = rs_push;
        obs_ready   = rn_ready;
        obs_payload = rs_payload;
        if (!r) begin
            check_eq("rn_ready", {31'd0, rn_ready}, {31'd0, e_ready});
            check_eq("rs_push", {28'd0, rs_push}, {28'd0, e_push});
            for (int k = 0; k < 4; k++) begin
                if (e_push[k]) begin
                    check_eq($sformatf("rs_payload%0d", k),
                             {24'd0, rs_payload[k*8 +: 8]}, {24'd0, e_pl[k]});
                end
            end
        end
        @(posedge clk);
        if (r || f) begin
            mq.delete();
        end else begin
            repeat (n_go) void'(mq.pop_front());
            if (v && e_ready) begin
                for (int i = 0; i < 2; i++) begin
                    if (sv[i]) mq.push_back('{rs: sel[i*2 +: 2], pl: pl[i*8 +: 8]});
                end
            end
        end
    endtask

    task automatic idle(input logic [3:0] full);
        step(1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 16'd0, full);
    endtask

    initial begin
        int cnt;

        // Reset
        step(1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 16'd0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 16'd0, 4'd0);
        idle(4'd0);
        check_eq("reset_payload", obs_payload, 32'd0);
        check_eq("reset_ready", {31'd0, obs_ready}, 32'd1);
        check_eq("reset_push", {28'd0, obs_push}, 32'd0);

        // Two slots to distinct RSs push together in T+1
        step(1'b0, 1'b0, 1'b1, 2'b11, {2'd2, 2'd1}, {8'hB2, 8'hA1}, 4'd0);
        idle(4'd0);
        check_eq("t1_push", {28'd0, obs_push}, 32'h6);
        check_eq("t1_pl1", {24'd0, obs_payload[15:8]}, 32'hA1);
        check_eq("t1_pl2", {24'd0, obs_payload[23:16]}, 32'hB2);
        check_eq("t1_ready", {31'd0, obs_ready}, 32'd1);

        // Both slots target RS0: serialized over two cycles
        step(1'b0, 1'b0, 1'b1, 2'b11, {2'd0, 2'd0}, {8'h22, 8'h11}, 4'd0);
        idle(4'd0);
        check_eq("t2_push_a", {28'd0, obs_push}, 32'h1);
        check_eq("t2_pl_a", {24'd0, obs_payload[7:0]}, 32'h11);
        check_eq("t2_ready_a", {31'd0, obs_ready}, 32'd0);
        idle(4'd0);
        check_eq("t2_push_b", {28'd0, obs_push}, 32'h1);
        check_eq("t2_pl_b", {24'd0, obs_payload[7:0]}, 32'h22);
        check_eq("t2_ready_b", {31'd0, obs_ready}, 32'd1);

        // Slot0 stalled by full RS3 holds slot1 back (in order)
        step(1'b0, 1'b0, 1'b1, 2'b11, {2'd0, 2'd3}, {8'h44, 8'h33}, 4'd0);
        for (int c = 0; c < 3; c++) begin
            idle(4'b1000);
            check_eq("t3_stall_push", {28'd0, obs_push}, 32'h0);
        end
        idle(4'd0);
        check_eq("t3_push", {28'd0, obs_push}, 32'h9);

        // Flush in the cycle the second conflicting slot would push
        step(1'b0, 1'b0, 1'b1, 2'b11, {2'd0, 2'd0}, {8'h66, 8'h55}, 4'd0);
        idle(4'd0);
        check_eq("t4_push_a", {28'd0, obs_push}, 32'h1);
        step(1'b0, 1'b1, 1'b0, 2'b00, 4'd0, 16'd0, 4'd0);
        check_eq("t4_flush_push", {28'd0, obs_push}, 32'h0);
        check_eq("t4_flush_ready", {31'd0, obs_ready}, 32'd0);
        idle(4'd0);
        check_eq("t4_after_push", {28'd0, obs_push}, 32'h0);
        check_eq("t4_after_ready", {31'd0, obs_ready}, 32'd1);

        // Flush together with rn_valid drops the group
        step(1'b0, 1'b1, 1'b1, 2'b11, {2'd1, 2'd0}, {8'h78, 8'h77}, 4'd0);
        idle(4'd0);
        check_eq("t4b_dropped", {28'd0, obs_push}, 32'h0);

        // Only slot1 valid
        step(1'b0, 1'b0, 1'b1, 2'b10, {2'd2, 2'd1}, {8'hC3, 8'h00}, 4'd0);
        idle(4'd0);
        check_eq("t5_push", {28'd0, obs_push}, 32'h4);
        check_eq("t5_pl", {24'd0, obs_payload[23:16]}, 32'hC3);

        // Eight back-to-back conflict-free groups
        cnt = 0;
        for (int g = 0; g < 8; g++) begin
            step(1'b0, 1'b0, 1'b1, 2'b11, {2'd1, 2'd0}, 16'($urandom), 4'd0);
            cnt += int'($countones(obs_push));
            check_eq("t6_ready", {31'd0, obs_ready}, 32'd1);
        end
        idle(4'd0);
        cnt += int'($countones(obs_push));
        check_eq("t6_pushes", cnt, 32'd16);

        // Randomized traffic against the queue model
        for (int n = 0; n < 600; n++) begin
            logic [3:0] full;
            for (int k = 0; k < 4; k++) full[k] = ($urandom_range(0, 3) == 0);
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 11) == 0),
                 1'($urandom), 2'($urandom), 4'($urandom), 16'($urandom), full);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_dispatch.md
# issue_dispatch

In-order dispatch scheduler between rename and the bank of reservation stations. It latches one renamed issue group of up to IW slots and steers each valid slot to the reservation station selected by its functional-unit class. Each RS accepts at most one push per cycle, so it serializes slot-to-RS conflicts and RS-full stalls over several cycles. It backpressures rename until every slot of the held group has been pushed.

## Interface
Parameters:
- CONFIG_P_ISSUE_WIDTH, default 1 — log2 of issue group width; IW = 1<<CONFIG_P_ISSUE_WIDTH.
- CONFIG_P_NUM_RS, default 2 — log2 of number of reservation stations; NRS = 1<<CONFIG_P_NUM_RS.
- PAYLOAD_W, default 64 — width of one slot's opaque RS payload (opcode buses, operands, ROB id/bank).

Ports:
- clk  in  1  clock; sole clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  pipeline flush; discards the held group.
- rn_valid  in  1  rename presents a group.
- rn_ready  out  1  dispatcher accepts the group this cycle.
- rn_slot_valid  in  IW  per-slot valid; slot 0 is oldest.
- rn_rs_sel  in  IW*CONFIG_P_NUM_RS  per-slot target RS index.
- rn_payload  in  IW*PAYLOAD_W  per-slot payload.
- rs_full  in  NRS  per-RS full flag; equals the RS's issue_rs_full, combinational from its free-vector flop.
- rs_push  out  NRS  per-RS push strobe; drives issue_push.
- rs_payload  out  NRS*PAYLOAD_W  per-RS payload; meaningful only when the matching rs_push is high.

## Operation
- State:
  - group buffer: payload and rs_sel per slot, loaded on accept.
  - pend[IW]: slots not yet dispatched.
  - buffer is empty when pend == 0.
- Accept: fire = rn_valid & rn_ready & ~flush.
  - On fire, pend <= rn_slot_valid and the buffer loads.
  - A group with rn_slot_valid == 0 is accepted and leaves pend = 0.
- Dispatch, combinational each cycle, scanning slots oldest to youngest:
  - slot i dispatches (go[i]) iff pend[i], ~rs_full[sel_i], no older slot j<i has pend[j] & ~go[j] (strictly in order), and no older slot with go set targets the same sel_i.
  - At most one push per RS per cycle; a same-RS conflict stops the scan at the younger slot.
- Outputs: for each RS k, rs_push[k] = OR over i of go[i] & (sel_i == k); rs_payload[k] = payload of that slot (at most one matches).
- Update: pend_nxt = pend & ~go. On fire, pend_nxt = new rn_slot_valid instead; the old group has fully dispatched in that cycle by definition of rn_ready.
- rn_ready = (pend & ~go) == 0. The buffer drains this cycle or is already empty, so back-to-back groups sustain one group per cycle with no conflicts.
- Flush has priority over everything:
  - rs_push forced to 0 and rn_ready forced to 0.
  - pend <= 0 next cycle.
- Reset: pend = 0; rs_push = 0; rs_payload = 0 from the cleared buffer; rn_ready = 1 in the first cycle after reset.

## Timing
- Latency: a group accepted in cycle T pushes its first slots in T+1, at the earliest.
- Worst case without full stalls: an IW-slot group that all targets one RS takes IW cycles.
- rs_full is sampled combinationally. The RS updates its free vector on the clock edge after the push, so the dispatcher never pushes twice into the same RS in one cycle. Pushing into an RS whose last entry frees in the same cycle is not allowed: rs_full is used as-is, with no bypass.
- rn_ready combinationally depends on rs_full and pend; no combinational path from rn_valid to rs_push.
- Simultaneous flush and rn_valid: group dropped, rn_ready low.
- rst asserted mid-drain: pend cleared next cycle; no further push.

## Structure
- NRS, IW and RS-class index encodings (ALU, LSU, BRU, EPU) go in ncpu64k_config.vh as `NCPU_RS_* defines; the RS-selection decode stays in rename.
- State elements:
  - pend uses mDFF_r (reset 0).
  - buffer payload and sel use mDFF_l loaded on fire.
- One sub-module is natural: issue_dispatch_sel. It holds the combinational in-order claim logic (pend, sel, rs_full -> go) and is unit-testable alone.

## Test plan
IW=2, NRS=4, PAYLOAD_W=8 in all cases.
- Reset, then group {slot0: RS1, 0xA1; slot1: RS2, 0xB2}, rs_full = 0 -> in T+1, rs_push = 4'b0110 with payloads 0xA1 and 0xB2; rn_ready = 1 throughout.
- Both slots target RS0 (0x11, 0x22) -> T+1: rs_push = 4'b0001, payload 0x11, rn_ready = 0; T+2: push 0x22, rn_ready = 1.
- Slot0 targets RS3 with rs_full[3] = 1 for 3 cycles; slot1 targets RS0 -> no push for 3 cycles (in order); on the 4th cycle both push together.
- flush asserted in the cycle the second of two conflicting slots would push -> no push that cycle; pend = 0 next cycle; rn_ready = 1.
- rn_slot_valid = 2'b10 (slot1 only, RS2) -> only rs_push[2] fires, in T+1.
- Back-to-back 8 conflict-free groups with rs_full = 0 -> 16 pushes in 8 consecutive cycles; rn_ready never deasserts.
